// File: rtl/regheap_acc_ctrl_if.sv
// Handshake and heap-side signal bundle for the register-heap accumulation sequencer.
// master is the sequencer; slave is the surrounding producer/heap/consumer environment.
interface regheap_acc_ctrl_if #(
    parameter int unsigned DATA_W = 1024,
    parameter int unsigned OUT_W  = 128,
    parameter int unsigned LEN_W  = 16
);
    logic              start;
    logic [LEN_W-1:0]  acc_len;
    logic              busy;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              heap_usr_rst;
    logic              heap_data_v;
    logic [DATA_W-1:0] heap_in_data;
    logic              heap_data_v_w;
    logic [DATA_W-1:0] heap_data_w;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_data;
    logic              out_last;
    logic              done;

    modport master (
        input  start, acc_len, in_valid, in_data, heap_data_v_w, heap_data_w, out_ready,
        output busy, in_ready, heap_usr_rst, heap_data_v, heap_in_data, out_valid, out_data,
               out_last, done
    );

    modport slave (
        output start, acc_len, in_valid, in_data, heap_data_v_w, heap_data_w, out_ready,
        input  busy, in_ready, heap_usr_rst, heap_data_v, heap_in_data, out_valid, out_data,
               out_last, done
    );
endinterface

// File: rtl/regheap_acc_ctrl.sv
// Sequencer for the 64x16b self-adding register heap: clear, accumulate N input
// vectors, wait for the heap to settle, then drain the sum as OUT_W-bit words.
module regheap_acc_ctrl #(
    parameter int unsigned DATA_W   = 1024,
    parameter int unsigned OUT_W    = 128,
    parameter int unsigned LEN_W    = 16,
    parameter int unsigned HEAP_LAT = 1
) (
    input  logic                clk,
    input  logic                rst,
    regheap_acc_ctrl_if.master  bus
);
    localparam int unsigned NWORDS = DATA_W / OUT_W;
    localparam int unsigned IdxW   = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam int unsigned LatW   = (HEAP_LAT > 1) ? $clog2(HEAP_LAT + 1) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NWORDS - 1);
    localparam logic [LatW-1:0] LatInit = LatW'(HEAP_LAT);

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StAccum,
        StSettle,
        StDrain,
        StDone
    } state_e;

    state_e            state_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  beat_cnt_q;
    logic [LatW-1:0]   lat_cnt_q;
    logic [IdxW-1:0]   word_idx_q;
    logic              busy_q;
    logic              in_ready_q;
    logic              usr_rst_q;
    logic              out_valid_q;
    logic              out_last_q;
    logic              done_q;

    logic                          accept;
    logic [NWORDS-1:0][OUT_W-1:0]  words;
    logic                          unused_heap_v_w;

    assign accept = in_ready_q & bus.in_valid;
    assign words  = bus.heap_data_w;
    // Output-valid from the heap is informational; settling is timed by HEAP_LAT.
    assign unused_heap_v_w = bus.heap_data_v_w;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StIdle;
            len_q       <= '0;
            beat_cnt_q  <= '0;
            lat_cnt_q   <= '0;
            word_idx_q  <= '0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            usr_rst_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            usr_rst_q <= 1'b0;
            done_q    <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        len_q     <= bus.acc_len;
                        busy_q    <= 1'b1;
                        usr_rst_q <= 1'b1;
                        state_q   <= StClear;
                    end
                end
                StClear: begin
                    beat_cnt_q <= '0;
                    if (len_q == '0) begin
                        lat_cnt_q <= LatInit;
                        state_q   <= StSettle;
                    end else begin
                        in_ready_q <= 1'b1;
                        state_q    <= StAccum;
                    end
                end
                StAccum: begin
                    if (accept) begin
                        if (beat_cnt_q == len_q - 1'b1) begin
                            in_ready_q <= 1'b0;
                            lat_cnt_q  <= LatInit;
                            state_q    <= StSettle;
                        end else begin
                            beat_cnt_q <= beat_cnt_q + 1'b1;
                        end
                    end
                end
                StSettle: begin
                    // Always spends at least one cycle here, even with HEAP_LAT of 0.
                    if (lat_cnt_q <= LatW'(1)) begin
                        word_idx_q  <= '0;
                        out_valid_q <= 1'b1;
                        out_last_q  <= (NWORDS == 1);
                        state_q     <= StDrain;
                    end else begin
                        lat_cnt_q <= lat_cnt_q - 1'b1;
                    end
                end
                StDrain: begin
                    if (bus.out_ready) begin
                        if (word_idx_q == LastIdx) begin
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            done_q      <= 1'b1;
                            state_q     <= StDone;
                        end else begin
                            word_idx_q <= word_idx_q + 1'b1;
                            out_last_q <= (word_idx_q + 1'b1 == LastIdx);
                        end
                    end
                end
                StDone: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    busy_q      <= 1'b0;
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                    out_last_q  <= 1'b0;
                    state_q     <= StIdle;
                end
            endcase
        end
    end

    assign bus.busy         = busy_q;
    assign bus.in_ready     = in_ready_q;
    assign bus.heap_usr_rst = usr_rst_q;
    assign bus.heap_data_v  = accept;
    assign bus.heap_in_data = accept ? bus.in_data : '0;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_data     = out_valid_q ? words[word_idx_q] : '0;
    assign bus.out_last     = out_last_q;
    assign bus.done         = done_q;

endmodule
